// File: rtl/cdb_arbiter_pkg.sv
// cdb_arbiter_pkg: shared widths, defaults and the CDB slot packet type
package cdb_arbiter_pkg;
    localparam int DEF_NUM_REQ = 8;
    localparam int DEF_CDB_W   = 3;
    localparam int PREG_W      = 6;
    typedef struct packed {
        logic              valid;
        logic [PREG_W-1:0] preg;
    } cdb_packet_t;
endpackage

// File: rtl/cdb_arbiter_rr_multi_pick.sv
// rr_multi_pick: rotating-priority picker granting up to CDB_W of NUM_REQ requesters
//  valid    in   requester valid bits
//  ptr      in   scan start index (rr_ptr)
//  grant    out  one-hot-per-requester grant vector
//  slot_idx out  requester index feeding each CDB slot, in scan order
//  slot_vld out  slot carries a grant (fills from slot 0, no gaps)
//  last_idx out  index of the last grant in scan order
//  count    out  number of grants
module rr_multi_pick #(
    parameter int NUM_REQ = 8,
    parameter int CDB_W   = 3,
    localparam int IDX_W  = $clog2(NUM_REQ),
    localparam int SLOT_W = $clog2(CDB_W + 1)
) (
    input  logic [NUM_REQ-1:0]          valid,
    input  logic [IDX_W-1:0]            ptr,
    output logic [NUM_REQ-1:0]          grant,
    output logic [CDB_W-1:0][IDX_W-1:0] slot_idx,
    output logic [CDB_W-1:0]            slot_vld,
    output logic [IDX_W-1:0]            last_idx,
    output logic [SLOT_W-1:0]           count
);
    logic [NUM_REQ-1:0] rot;
    logic [IDX_W-1:0]   idx;
    always_comb begin
        rot      = NUM_REQ'({valid, valid} >> ptr);
        grant    = '0;
        slot_idx = '0;
        slot_vld = '0;
        last_idx = '0;
        count    = '0;
        idx      = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            // rotated position j maps back to requester j+ptr (NUM_REQ is a power of 2)
            idx = IDX_W'(j) + ptr;
            if (rot[j] && count < SLOT_W'(CDB_W)) begin
                grant[idx]      = 1'b1;
                slot_idx[count] = idx;
                slot_vld[count] = 1'b1;
                last_idx        = idx;
                count           = count + 1'b1;
            end
        end
    end
endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin arbitration of FU completions onto a registered N-wide CDB
//  clock        in   system clock
//  reset        in   asynchronous active-low reset
//  req_valid    in   FU i has a completed result
//  req_preg     in   destination phys reg of FU i
//  req_ready    out  FU i granted this cycle
//  squash       in   mispredict flush, blocks all grants this cycle
//  cdb_valid    out  slot k broadcasting
//  cdb_preg     out  slot k phys reg
//  num_granted  out  grants issued this cycle
//  perf_bcast   out  broadcast counter (CDB_PERF_CNT_EN)
//  perf_stall   out  denied-request counter (CDB_PERF_CNT_EN)
// Macro CDB_PERF_CNT_EN enables the perf counters; otherwise they are tied to 0.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int CDB_W   = DEF_CDB_W,
    localparam int IDX_W  = $clog2(NUM_REQ),
    localparam int NSB    = $clog2(CDB_W + 1)
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ-1:0][PREG_W-1:0] req_preg,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic                           squash,
    output logic [CDB_W-1:0]               cdb_valid,
    output logic [CDB_W-1:0][PREG_W-1:0]   cdb_preg,
    output logic [NSB-1:0]                 num_granted,
    output logic [31:0]                    perf_bcast,
    output logic [31:0]                    perf_stall
);
    logic [IDX_W-1:0]            rr_ptr;
    logic [NUM_REQ-1:0]          grant;
    logic [CDB_W-1:0][IDX_W-1:0] slot_idx;
    logic [CDB_W-1:0]            slot_vld;
    logic [IDX_W-1:0]            last_idx;
    cdb_packet_t [CDB_W-1:0]     nxt, cdb_q;
    logic [CDB_W-1:0]            nxt_valid;

    rr_multi_pick #(.NUM_REQ(NUM_REQ), .CDB_W(CDB_W)) u_pick (
        .valid    (req_valid & {NUM_REQ{reset & ~squash}}),
        .ptr      (rr_ptr),
        .grant    (grant),
        .slot_idx (slot_idx),
        .slot_vld (slot_vld),
        .last_idx (last_idx),
        .count    (num_granted)
    );

    assign req_ready = grant;

    // A granted preg of 0 is consumed but never broadcast as valid.
    always_comb begin
        nxt       = '0;
        nxt_valid = '0;
        for (int k = 0; k < CDB_W; k++) begin
            nxt[k].preg  = slot_vld[k] ? req_preg[slot_idx[k]] : '0;
            nxt[k].valid = slot_vld[k] && (nxt[k].preg != '0);
            nxt_valid[k] = nxt[k].valid;
            cdb_valid[k] = cdb_q[k].valid;
            cdb_preg[k]  = cdb_q[k].preg;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cdb_q  <= '0;
            rr_ptr <= '0;
        end else begin
            cdb_q  <= nxt;
            rr_ptr <= (|grant) ? last_idx + 1'b1 : rr_ptr;
        end
    end

`ifdef CDB_PERF_CNT_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            perf_bcast <= '0;
            perf_stall <= '0;
        end else begin
            perf_bcast <= perf_bcast + 32'($countones(nxt_valid));
            perf_stall <= perf_stall + 32'($countones(req_valid & ~req_ready));
        end
    end
`else
    assign perf_bcast = '0;
    assign perf_stall = '0;
`endif

    // Upstream guarantees unique destination pregs among broadcast slots.
    for (genvar i = 0; i < CDB_W; i++) begin : g_a
        for (genvar j = i + 1; j < CDB_W; j++) begin : g_b
            a_uniq: assert property (@(posedge clock) disable iff (!reset)
                !(nxt[i].valid && nxt[j].valid && nxt[i].preg == nxt[j].preg));
        end
    end
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed self-checking bench for cdb_arbiter (NUM_REQ=8, CDB_W=3)
module tb_cdb_arbiter;
    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic [7:0]      req_valid = '0;
    logic [7:0][5:0] req_preg = '0;
    logic [7:0]      req_ready;
    logic            squash = 1'b0;
    logic [2:0]      cdb_valid;
    logic [2:0][5:0] cdb_preg;
    logic [1:0]      num_granted;
    logic [31:0]     perf_bcast, perf_stall;
    int              n_checks = 0;
    int              n_fail = 0;
    logic [31:0]     b0, s0;

    cdb_arbiter #(.NUM_REQ(8), .CDB_W(3)) dut (
        .clock       (clock),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_preg    (req_preg),
        .req_ready   (req_ready),
        .squash      (squash),
        .cdb_valid   (cdb_valid),
        .cdb_preg    (cdb_preg),
        .num_granted (num_granted),
        .perf_bcast  (perf_bcast),
        .perf_stall  (perf_stall)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic default_pregs();
        for (int i = 0; i < 8; i++) req_preg[i] = 6'(10 + i);
    endtask

    task automatic check_perf(input string tag, input logic [31:0] eb, input logic [31:0] es);
`ifdef CDB_PERF_CNT_EN
        check({tag, "_bcast"}, perf_bcast, eb);
        check({tag, "_stall"}, perf_stall, es);
`else
        check({tag, "_bcast"}, perf_bcast, 32'd0);
        check({tag, "_stall"}, perf_stall, 32'd0);
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        default_pregs();
        repeat (2) @(posedge clock);
        #1;
        check("rst_cdb_valid", 32'(cdb_valid), 32'd0);
        check("rst_cdb_preg", 32'(cdb_preg), 32'd0);
        req_valid = 8'hFF;
        #1;
        check("rst_ready", 32'(req_ready), 32'd0);
        check_perf("rst", 32'd0, 32'd0);
        req_valid = 8'h00;
        reset = 1'b1;
        tick();
        // test 1: all valid, held until granted
        req_valid = 8'hFF;
        #1;
        check("t1_ready0", 32'(req_ready), 32'h07);
        check("t1_num0", 32'(num_granted), 32'd3);
        tick();
        check("t1_valid0", 32'(cdb_valid), 32'b111);
        check("t1_preg0", 32'(cdb_preg), 32'({6'd12, 6'd11, 6'd10}));
        req_valid = 8'hF8;
        #1;
        check("t1_ready1", 32'(req_ready), 32'h38);
        tick();
        check("t1_valid1", 32'(cdb_valid), 32'b111);
        check("t1_preg1", 32'(cdb_preg), 32'({6'd15, 6'd14, 6'd13}));
        req_valid = 8'hC0;
        #1;
        check("t1_ready2", 32'(req_ready), 32'hC0);
        check("t1_num2", 32'(num_granted), 32'd2);
        tick();
        check("t1_valid2", 32'(cdb_valid), 32'b011);
        check("t1_preg2", 32'(cdb_preg), 32'({6'd0, 6'd17, 6'd16}));
        check_perf("t1", 32'd8, 32'd7);
        req_valid = 8'h00;
        #1;
        check("t1_idle_ready", 32'(req_ready), 32'd0);
        tick();
        check("t1_idle_valid", 32'(cdb_valid), 32'd0);
        // test 2: walk rr_ptr to 6, then wrap 6,7,0
        req_preg[5] = 6'd20;
        req_valid = 8'h20;
        #1;
        check("t2_ready_pre", 32'(req_ready), 32'h20);
        tick();
        check("t2_pre_cdb", 32'(cdb_preg), 32'd20);
        req_preg[6] = 6'd40;
        req_preg[7] = 6'd41;
        req_preg[0] = 6'd42;
        req_valid = 8'hC1;
        #1;
        check("t2_ready", 32'(req_ready), 32'hC1);
        tick();
        check("t2_valid", 32'(cdb_valid), 32'b111);
        check("t2_preg", 32'(cdb_preg), 32'({6'd42, 6'd41, 6'd40}));
        default_pregs();
        req_valid = 8'hFF;
        #1;
        check("t2_ptr1", 32'(req_ready), 32'h0E);
        tick();
        // test 3: sparse single requester at rr_ptr=4
        req_preg[4] = 6'd33;
        req_valid = 8'h10;
        #1;
        check("t3_ready", 32'(req_ready), 32'h10);
        check("t3_num", 32'(num_granted), 32'd1);
        tick();
        check("t3_valid", 32'(cdb_valid), 32'b001);
        check("t3_preg", 32'(cdb_preg), 32'd33);
        req_valid = 8'hFF;
        #1;
        check("t3_ptr5", 32'(req_ready), 32'hE0);
        tick();
        // test 4: squash holds off grants but not the slots already broadcasting
        req_valid = 8'h80;
        #1;
        check("t4_pre_ready", 32'(req_ready), 32'h80);
        tick();
        squash = 1'b1;
        req_valid = 8'h07;
        #1;
        check("t4_sq_ready", 32'(req_ready), 32'd0);
        check("t4_sq_num", 32'(num_granted), 32'd0);
        check("t4_sq_keep", 32'(cdb_valid), 32'b001);
        check("t4_sq_keep_preg", 32'(cdb_preg), 32'd17);
        tick();
        check("t4_sq_cdb", 32'(cdb_valid), 32'd0);
        squash = 1'b0;
        #1;
        check("t4_after_ready", 32'(req_ready), 32'h07);
        tick();
        check("t4_after_preg", 32'(cdb_preg), 32'({6'd12, 6'd11, 6'd10}));
        // test 5: zero preg consumes a slot but never broadcasts (rr_ptr=3)
        req_preg[1] = 6'd0;
        req_preg[2] = 6'd9;
        req_valid = 8'h06;
        #1;
        b0 = perf_bcast;
        s0 = perf_stall;
        check("t5_ready", 32'(req_ready), 32'h06);
        tick();
        check("t5_valid", 32'(cdb_valid), 32'b010);
        check("t5_preg", 32'(cdb_preg), 32'({6'd0, 6'd9, 6'd0}));
`ifdef CDB_PERF_CNT_EN
        check("t5_bcast_delta", perf_bcast - b0, 32'd1);
        check("t5_stall_delta", perf_stall - s0, 32'd0);
`endif
        // test 6: async reset mid-burst (rr_ptr=3)
        default_pregs();
        req_valid = 8'hFF;
        #1;
        check("t6_ready", 32'(req_ready), 32'h38);
        tick();
        check("t6_valid", 32'(cdb_valid), 32'b111);
        req_valid = 8'hC7;
        #2;
        reset = 1'b0;
        #1;
        check("t6_rst_valid", 32'(cdb_valid), 32'd0);
        check("t6_rst_ready", 32'(req_ready), 32'd0);
        check_perf("t6_rst", 32'd0, 32'd0);
        #1;
        reset = 1'b1;
        #1;
        check("t6_restart", 32'(req_ready), 32'h07);
        tick();
        check("t6_restart_preg", 32'(cdb_preg), 32'({6'd12, 6'd11, 6'd10}));
        req_valid = 8'h00;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
